// File: rtl/btb_pkg.sv
// Shared types for the BTB write scheduler: branch types, bimodal update payload
// and the registered BTB write-port bundle.
package btb_pkg;

  localparam int unsigned BTB_SETS = 32;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_CALL = 2'b01,
    BR_JUMP = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  // Commit-time bimodal counter update, queued until the BTB port is free
  typedef struct packed {
    logic [31:0] vpc;
    logic [1:0]  cntr;
    logic        tkn;
    logic        way;
  } bm_upd_t;

  // One cycle of BTB write-port drive; at most one of mod/correct/bm is set
  typedef struct packed {
    logic        steal;
    logic        mod;
    logic        correct;
    logic        bm;
    logic [31:0] correct_pc;
    logic [31:0] vpc;
    logic [31:0] target;
    logic [1:0]  cntr;
    logic        tkn;
    br_type_e    btype;
    logic        present;
    logic        way;
  } btb_wr_t;

endpackage

// File: rtl/btb_bm_fifo.sv
// Synchronous FIFO of bimodal updates. Pointers carry an extra wrap bit so that
// full and empty fall out of pointer comparison; flags and head are
// combinational views of the registered pointers.
module btb_bm_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  bm_upd_t wdata_i,
  output bm_upd_t rdata_c,
  output logic    full_c,
  output logic    empty_c
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  bm_upd_t          mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Flags from pointer equality plus wrap-bit difference
  always_comb begin
    empty_c = (wptr_q == rptr_q);
    full_c  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
              (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    rdata_c = mem_q[rptr_q[ADDR_W-1:0]];
  end

  // Pointer advance; push while full and pop while empty are ignored
  always_comb begin
    do_push = push_i & ~full_c;
    do_pop  = pop_i & ~empty_c;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
  end

  // Pointer registers; reset discards any queued entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage, not reset: contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[ADDR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/btb_update_sched.sv
// Serialises all writes to the single-ported BTB: commit modifies, decode
// corrections and queued bimodal updates, in that priority. Every write issued
// flags if1_steal_o because it corrupts that cycle's lookup.
// Optional: define BTB_SCHED_PERF_EN for drop/steal performance counters.
module btb_update_sched
  import btb_pkg::*;
#(
  parameter int unsigned BM_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic        cpu_clk_i,
  input  logic        reset_i,
  input  logic        fetch_active_i,
  input  logic        flush_i,
  input  logic        dec_corr_vld_i,
  input  logic [31:0] dec_corr_pc_i,
  input  logic        cm_mod_vld_i,
  input  logic [31:0] cm_vpc_i,
  input  logic [31:0] cm_target_i,
  input  logic [1:0]  cm_cntr_i,
  input  logic        cm_tkn_i,
  input  logic [1:0]  cm_type_i,
  input  logic        cm_present_i,
  input  logic        bm_vld_i,
  input  logic [31:0] bm_vpc_i,
  input  logic [1:0]  bm_cntr_i,
  input  logic        bm_tkn_i,
  input  logic        bm_way_i,
  output logic        bm_rdy_o,
  output logic        btb_correct_o,
  output logic [31:0] btb_correct_pc_o,
  output logic        c1_btb_mod_o,
  output logic        c1_btb_bm_o,
  output logic [31:0] c1_btb_vpc_o,
  output logic [31:0] c1_btb_target_o,
  output logic [1:0]  c1_cntr_pred_o,
  output logic        c1_bnch_tkn_o,
  output logic [1:0]  c1_bnch_type_o,
  output logic        c1_bnch_present_o,
  output logic        c1_btb_way_o,
  output logic        if1_steal_o
`ifdef BTB_SCHED_PERF_EN
  ,
  output logic [31:0] perf_bm_drop_o,
  output logic [31:0] perf_steal_o
`endif
);

  localparam int unsigned STARVE_W =
    ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  btb_wr_t             out_q, out_d;
  logic                corr_vld_q, corr_vld_d;
  logic [31:0]         corr_pc_q, corr_pc_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  bm_upd_t             bm_wdata;
  bm_upd_t             bm_head;
  logic                bm_full;
  logic                bm_empty;
  logic                bm_push;
  logic                bm_pop;
  logic                corr_fire;
  logic                starved;

  btb_bm_fifo #(
    .DEPTH (BM_DEPTH)
  ) u_bm_fifo (
    .clk     (cpu_clk_i),
    .rst_n   (reset_i),
    .push_i  (bm_push),
    .pop_i   (bm_pop),
    .wdata_i (bm_wdata),
    .rdata_c (bm_head),
    .full_c  (bm_full),
    .empty_c (bm_empty)
  );

  // Ready tracks the registered full flag only, so a push into a full FIFO is
  // dropped even when the head drains in the same cycle
  assign bm_rdy_o = reset_i & ~bm_full;

  // Port arbitration: commit modify > pending correction > bimodal head
  always_comb begin
    bm_wdata  = '{vpc: bm_vpc_i, cntr: bm_cntr_i, tkn: bm_tkn_i, way: bm_way_i};
    bm_push   = bm_vld_i & bm_rdy_o;
    starved   = (starve_q == STARVE_W'(STARVE_MAX));
    corr_fire = corr_vld_q & ~cm_mod_vld_i & ~flush_i;
    bm_pop    = reset_i & ~cm_mod_vld_i & ~corr_fire & ~bm_empty &
                (~fetch_active_i | starved | bm_full);

    out_d = '0;
    if (cm_mod_vld_i) begin
      out_d.mod     = 1'b1;
      out_d.vpc     = cm_vpc_i;
      out_d.target  = cm_target_i;
      out_d.cntr    = cm_cntr_i;
      out_d.tkn     = cm_tkn_i;
      out_d.btype   = br_type_e'(cm_type_i);
      out_d.present = cm_present_i;
    end else if (corr_fire) begin
      out_d.correct    = 1'b1;
      out_d.correct_pc = corr_pc_q;
      out_d.vpc        = corr_pc_q;
    end else if (bm_pop) begin
      out_d.bm   = 1'b1;
      out_d.vpc  = bm_head.vpc;
      out_d.cntr = bm_head.cntr;
      out_d.tkn  = bm_head.tkn;
      out_d.way  = bm_head.way;
    end
    out_d.steal = out_d.mod | out_d.correct | out_d.bm;
  end

  // Pending decode correction: flush or a commit modify discards it
  always_comb begin
    corr_vld_d = corr_vld_q;
    corr_pc_d  = corr_pc_q;
    if (flush_i || cm_mod_vld_i) begin
      corr_vld_d = 1'b0;
    end else if (dec_corr_vld_i) begin
      corr_vld_d = 1'b1;
      corr_pc_d  = dec_corr_pc_i;
    end else if (corr_fire) begin
      corr_vld_d = 1'b0;
    end
  end

  // Starvation counter: counts deferred cycles of a non-empty FIFO, saturating
  always_comb begin
    starve_d = starve_q;
    if (bm_empty || bm_pop) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge cpu_clk_i) begin
    if (!reset_i) begin
      out_q      <= '0;
      corr_vld_q <= 1'b0;
      corr_pc_q  <= '0;
      starve_q   <= '0;
    end else begin
      out_q      <= out_d;
      corr_vld_q <= corr_vld_d;
      corr_pc_q  <= corr_pc_d;
      starve_q   <= starve_d;
    end
  end

  assign btb_correct_o     = out_q.correct;
  assign btb_correct_pc_o  = out_q.correct_pc;
  assign c1_btb_mod_o      = out_q.mod;
  assign c1_btb_bm_o       = out_q.bm;
  assign c1_btb_vpc_o      = out_q.vpc;
  assign c1_btb_target_o   = out_q.target;
  assign c1_cntr_pred_o    = out_q.cntr;
  assign c1_bnch_tkn_o     = out_q.tkn;
  assign c1_bnch_type_o    = out_q.btype;
  assign c1_bnch_present_o = out_q.present;
  assign c1_btb_way_o      = out_q.way;
  assign if1_steal_o       = out_q.steal;

`ifdef BTB_SCHED_PERF_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] steal_cnt_q, steal_cnt_d;
  logic        fetch_active_q;

  // Wrapping counters: dropped pushes, and steals that hit a real lookup
  always_comb begin
    drop_cnt_d  = drop_cnt_q + 32'(bm_vld_i & ~bm_rdy_o);
    steal_cnt_d = steal_cnt_q + 32'(out_q.steal & fetch_active_q);
  end

  // Counter registers; fetch activity delayed to line up with registered steal
  always_ff @(posedge cpu_clk_i) begin
    if (!reset_i) begin
      drop_cnt_q     <= '0;
      steal_cnt_q    <= '0;
      fetch_active_q <= 1'b0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      steal_cnt_q    <= steal_cnt_d;
      fetch_active_q <= fetch_active_i;
    end
  end

  assign perf_bm_drop_o = drop_cnt_q;
  assign perf_steal_o   = steal_cnt_q;
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched: reset, commit modify, decode correction
// and its discard paths, idle drain, starvation limit, overflow, reset mid-drain.
module tb_btb_update_sched;

  logic        cpu_clk_i;
  logic        reset_i;
  logic        fetch_active_i;
  logic        flush_i;
  logic        dec_corr_vld_i;
  logic [31:0] dec_corr_pc_i;
  logic        cm_mod_vld_i;
  logic [31:0] cm_vpc_i;
  logic [31:0] cm_target_i;
  logic [1:0]  cm_cntr_i;
  logic        cm_tkn_i;
  logic [1:0]  cm_type_i;
  logic        cm_present_i;
  logic        bm_vld_i;
  logic [31:0] bm_vpc_i;
  logic [1:0]  bm_cntr_i;
  logic        bm_tkn_i;
  logic        bm_way_i;
  logic        bm_rdy_o;
  logic        btb_correct_o;
  logic [31:0] btb_correct_pc_o;
  logic        c1_btb_mod_o;
  logic        c1_btb_bm_o;
  logic [31:0] c1_btb_vpc_o;
  logic [31:0] c1_btb_target_o;
  logic [1:0]  c1_cntr_pred_o;
  logic        c1_bnch_tkn_o;
  logic [1:0]  c1_bnch_type_o;
  logic        c1_bnch_present_o;
  logic        c1_btb_way_o;
  logic        if1_steal_o;
`ifdef BTB_SCHED_PERF_EN
  logic [31:0] perf_bm_drop_o;
  logic [31:0] perf_steal_o;
`endif

  int checks   = 0;
  int failures = 0;

  btb_update_sched #(
    .BM_DEPTH   (4),
    .STARVE_MAX (7)
  ) dut (
    .cpu_clk_i         (cpu_clk_i),
    .reset_i           (reset_i),
    .fetch_active_i    (fetch_active_i),
    .flush_i           (flush_i),
    .dec_corr_vld_i    (dec_corr_vld_i),
    .dec_corr_pc_i     (dec_corr_pc_i),
    .cm_mod_vld_i      (cm_mod_vld_i),
    .cm_vpc_i          (cm_vpc_i),
    .cm_target_i       (cm_target_i),
    .cm_cntr_i         (cm_cntr_i),
    .cm_tkn_i          (cm_tkn_i),
    .cm_type_i         (cm_type_i),
    .cm_present_i      (cm_present_i),
    .bm_vld_i          (bm_vld_i),
    .bm_vpc_i          (bm_vpc_i),
    .bm_cntr_i         (bm_cntr_i),
    .bm_tkn_i          (bm_tkn_i),
    .bm_way_i          (bm_way_i),
    .bm_rdy_o          (bm_rdy_o),
    .btb_correct_o     (btb_correct_o),
    .btb_correct_pc_o  (btb_correct_pc_o),
    .c1_btb_mod_o      (c1_btb_mod_o),
    .c1_btb_bm_o       (c1_btb_bm_o),
    .c1_btb_vpc_o      (c1_btb_vpc_o),
    .c1_btb_target_o   (c1_btb_target_o),
    .c1_cntr_pred_o    (c1_cntr_pred_o),
    .c1_bnch_tkn_o     (c1_bnch_tkn_o),
    .c1_bnch_type_o    (c1_bnch_type_o),
    .c1_bnch_present_o (c1_bnch_present_o),
    .c1_btb_way_o      (c1_btb_way_o),
    .if1_steal_o       (if1_steal_o)
`ifdef BTB_SCHED_PERF_EN
    ,
    .perf_bm_drop_o    (perf_bm_drop_o),
    .perf_steal_o      (perf_steal_o)
`endif
  );

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; also checks the
  // one-hot issue and steal invariants every cycle
  task automatic tick();
    @(posedge cpu_clk_i);
    #1;
    chk("onehot", 32'($countones({c1_btb_mod_o, btb_correct_o, c1_btb_bm_o}) <= 1), 32'd1);
    chk("steal_or", 32'(if1_steal_o), 32'(c1_btb_mod_o | btb_correct_o | c1_btb_bm_o));
  endtask

  task automatic clear_req();
    flush_i        = 1'b0;
    dec_corr_vld_i = 1'b0;
    dec_corr_pc_i  = '0;
    cm_mod_vld_i   = 1'b0;
    cm_vpc_i       = '0;
    cm_target_i    = '0;
    cm_cntr_i      = '0;
    cm_tkn_i       = 1'b0;
    cm_type_i      = '0;
    cm_present_i   = 1'b0;
    bm_vld_i       = 1'b0;
    bm_vpc_i       = '0;
    bm_cntr_i      = '0;
    bm_tkn_i       = 1'b0;
    bm_way_i       = 1'b0;
  endtask

  task automatic push_bm(input logic [31:0] vpc, input logic [1:0] cntr,
                         input logic tkn, input logic way);
    bm_vld_i  = 1'b1;
    bm_vpc_i  = vpc;
    bm_cntr_i = cntr;
    bm_tkn_i  = tkn;
    bm_way_i  = way;
  endtask

  // Expected bimodal issue: strobe, vpc, counter, taken, way
  task automatic chk_bm(input string tag, input logic [31:0] vpc, input logic [1:0] cntr,
                        input logic tkn, input logic way);
    chk({tag, "_bm"}, 32'(c1_btb_bm_o), 32'd1);
    chk({tag, "_vpc"}, c1_btb_vpc_o, vpc);
    chk({tag, "_cntr"}, 32'(c1_cntr_pred_o), 32'(cntr));
    chk({tag, "_tkn"}, 32'(c1_bnch_tkn_o), 32'(tkn));
    chk({tag, "_way"}, 32'(c1_btb_way_o), 32'(way));
  endtask

  logic [31:0] ivpc [3];
  logic [1:0]  icnt [3];
  logic        itkn [3];
  logic        iway [3];

  initial begin
    reset_i        = 1'b0;
    fetch_active_i = 1'b0;
    clear_req();

    // Reset with random traffic: nothing issues, ready held low
    for (int i = 0; i < 3; i++) begin
      fetch_active_i = 1'($urandom);
      dec_corr_vld_i = 1'b1;
      dec_corr_pc_i  = $urandom;
      cm_mod_vld_i   = 1'($urandom);
      cm_vpc_i       = $urandom;
      bm_vld_i       = 1'b1;
      bm_vpc_i       = $urandom;
      tick();
      chk("rst_steal", 32'(if1_steal_o), 32'd0);
      chk("rst_mod", 32'(c1_btb_mod_o), 32'd0);
      chk("rst_bm", 32'(c1_btb_bm_o), 32'd0);
      chk("rst_corr", 32'(btb_correct_o), 32'd0);
      chk("rst_vpc", c1_btb_vpc_o, 32'd0);
      chk("rst_rdy", 32'(bm_rdy_o), 32'd0);
    end
    reset_i        = 1'b1;
    fetch_active_i = 1'b0;
    clear_req();
    tick();
    chk("post_rst_rdy", 32'(bm_rdy_o), 32'd1);
    chk("post_rst_steal", 32'(if1_steal_o), 32'd0);
    tick();
    chk("post_rst_bm", 32'(c1_btb_bm_o), 32'd0);

    // Commit modify issues next cycle with all fields copied
    cm_mod_vld_i = 1'b1;
    cm_vpc_i     = 32'h0000_1048;
    cm_target_i  = 32'h0000_2000;
    cm_present_i = 1'b1;
    cm_cntr_i    = 2'b10;
    cm_tkn_i     = 1'b1;
    cm_type_i    = 2'b01;
    tick();
    clear_req();
    chk("mod_strobe", 32'(c1_btb_mod_o), 32'd1);
    chk("mod_vpc", c1_btb_vpc_o, 32'h0000_1048);
    chk("mod_target", c1_btb_target_o, 32'h0000_2000);
    chk("mod_present", 32'(c1_bnch_present_o), 32'd1);
    chk("mod_cntr", 32'(c1_cntr_pred_o), 32'd2);
    chk("mod_tkn", 32'(c1_bnch_tkn_o), 32'd1);
    chk("mod_type", 32'(c1_bnch_type_o), 32'd1);
    chk("mod_steal", 32'(if1_steal_o), 32'd1);
    tick();
    chk("mod_done", 32'(c1_btb_mod_o), 32'd0);

    // Correction in the same cycle as a commit modify is discarded
    dec_corr_vld_i = 1'b1;
    dec_corr_pc_i  = 32'h100;
    cm_mod_vld_i   = 1'b1;
    cm_vpc_i       = 32'h300;
    tick();
    clear_req();
    chk("disc_mod", 32'(c1_btb_mod_o), 32'd1);
    chk("disc_corr0", 32'(btb_correct_o), 32'd0);
    tick();
    chk("disc_corr1", 32'(btb_correct_o), 32'd0);
    tick();
    chk("disc_corr2", 32'(btb_correct_o), 32'd0);

    // Correction together with flush captures nothing
    dec_corr_vld_i = 1'b1;
    dec_corr_pc_i  = 32'h100;
    flush_i        = 1'b1;
    tick();
    clear_req();
    chk("flush_steal0", 32'(if1_steal_o), 32'd0);
    tick();
    chk("flush_steal1", 32'(if1_steal_o), 32'd0);
    tick();
    chk("flush_corr", 32'(btb_correct_o), 32'd0);

    // Plain correction: captured, then issued with zeroed entry fields
    dec_corr_vld_i = 1'b1;
    dec_corr_pc_i  = 32'h140;
    tick();
    clear_req();
    chk("corr_capt", 32'(btb_correct_o), 32'd0);
    tick();
    chk("corr_strobe", 32'(btb_correct_o), 32'd1);
    chk("corr_pc", btb_correct_pc_o, 32'h140);
    chk("corr_present", 32'(c1_bnch_present_o), 32'd0);
    chk("corr_target", c1_btb_target_o, 32'd0);
    chk("corr_cntr", 32'(c1_cntr_pred_o), 32'd0);
    chk("corr_type", 32'(c1_bnch_type_o), 32'd0);
    tick();
    chk("corr_once", 32'(btb_correct_o), 32'd0);

    // Pending correction cleared by flush
    dec_corr_vld_i = 1'b1;
    dec_corr_pc_i  = 32'h180;
    tick();
    clear_req();
    flush_i = 1'b1;
    tick();
    clear_req();
    tick();
    chk("pend_flush", 32'(btb_correct_o), 32'd0);

    // Pending correction discarded by a later commit modify
    dec_corr_vld_i = 1'b1;
    dec_corr_pc_i  = 32'h1c0;
    tick();
    clear_req();
    cm_mod_vld_i = 1'b1;
    cm_vpc_i     = 32'h500;
    tick();
    clear_req();
    chk("pend_mod", 32'(c1_btb_mod_o), 32'd1);
    chk("pend_mod_vpc", c1_btb_vpc_o, 32'h500);
    tick();
    chk("pend_mod_corr", 32'(btb_correct_o), 32'd0);

    // Idle drain: three pushes issue on consecutive cycles, in order
    fetch_active_i = 1'b0;
    ivpc[0] = 32'hA0; icnt[0] = 2'd1; itkn[0] = 1'b0; iway[0] = 1'b1;
    ivpc[1] = 32'hA4; icnt[1] = 2'd2; itkn[1] = 1'b1; iway[1] = 1'b0;
    ivpc[2] = 32'hA8; icnt[2] = 2'd3; itkn[2] = 1'b1; iway[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_bm(ivpc[i], icnt[i], itkn[i], iway[i]);
      tick();
      if (i == 0) chk("idle_first", 32'(c1_btb_bm_o), 32'd0);
      else        chk_bm("idle", ivpc[i-1], icnt[i-1], itkn[i-1], iway[i-1]);
    end
    clear_req();
    tick();
    chk_bm("idle_last", ivpc[2], icnt[2], itkn[2], iway[2]);
    tick();
    chk("idle_empty", 32'(c1_btb_bm_o), 32'd0);

    // Starvation: with fetch busy the update issues 8 cycles after the push edge
    fetch_active_i = 1'b1;
    push_bm(32'hB0, 2'd2, 1'b0, 1'b1);
    tick();
    clear_req();
    chk("starve_push", 32'(c1_btb_bm_o), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) chk("starve_wait", 32'(c1_btb_bm_o), 32'd0);
      else       chk_bm("starve_issue", 32'hB0, 2'd2, 1'b0, 1'b1);
    end
    tick();
    chk("starve_after", 32'(c1_btb_bm_o), 32'd0);

    // Overflow: six back-to-back pushes with fetch busy; the fifth is dropped
    for (int i = 0; i < 6; i++) begin
      push_bm(32'hC0 + 32'(i * 4), 2'(i), 1'(i), 1'(i >> 1));
      chk("ovf_rdy", 32'(bm_rdy_o), (i == 4) ? 32'd0 : 32'd1);
      tick();
      if (i == 4) chk_bm("ovf_forced", 32'hC0, 2'd0, 1'b0, 1'b0);
      else        chk("ovf_none", 32'(c1_btb_bm_o), 32'd0);
    end
    clear_req();
    chk("ovf_full_rdy", 32'(bm_rdy_o), 32'd0);
    tick();
    chk_bm("ovf_forced2", 32'hC4, 2'd1, 1'b1, 1'b0);
    tick();
    chk("ovf_defer", 32'(c1_btb_bm_o), 32'd0);
    fetch_active_i = 1'b0;
    tick();
    chk_bm("ovf_drain0", 32'hC8, 2'd2, 1'b0, 1'b1);
    tick();
    chk_bm("ovf_drain1", 32'hCC, 2'd3, 1'b1, 1'b1);
    tick();
    chk_bm("ovf_drain2", 32'hD4, 2'd1, 1'b1, 1'b0);
    tick();
    chk("ovf_empty", 32'(c1_btb_bm_o), 32'd0);
`ifdef BTB_SCHED_PERF_EN
    chk("perf_drop", perf_bm_drop_o, 32'd1);
`endif

    // Reset mid-drain loses queued updates
    fetch_active_i = 1'b1;
    push_bm(32'hE0, 2'd1, 1'b1, 1'b0);
    tick();
    push_bm(32'hE4, 2'd2, 1'b0, 1'b1);
    tick();
    clear_req();
    reset_i = 1'b0;
    tick();
    chk("mid_rst_bm", 32'(c1_btb_bm_o), 32'd0);
    reset_i        = 1'b1;
    fetch_active_i = 1'b0;
    tick();
    chk("mid_rst_drain0", 32'(c1_btb_bm_o), 32'd0);
    tick();
    chk("mid_rst_drain1", 32'(c1_btb_bm_o), 32'd0);
    chk("mid_rst_rdy", 32'(bm_rdy_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
